alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Queues ALU commands and issues them one at a time to the shared clocked ALU (ALUnit). Each command is {oper, A, B}.
- Waits a fixed ALU latency, then captures the result and the Z/V/C/N flags.
- Presents the result on a valid/ready output port.
- Sits between the front-panel/operand-entry logic (or any other command source) and ALUnit, replacing direct "run" wiring of oper/A/B.

Parameters:
- DATA_W, 32, operand and result width.
- FIFO_DEPTH, 4, command queue entries; must be a power of 2, at least 2.
- ALU_LAT, 1, clock edges ALUnit needs to produce dataOut after sampling its inputs; at least 1.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  queue can accept a command.
- cmd_oper  in  3  ALU opcode: NOP=000, ADD, SUB, AND, OR, XOR, SLT, SLL=111.
- cmd_a  in  DATA_W  operand A.
- cmd_b  in  DATA_W  operand B.
- alu_oper  out  3  to ALUnit oper.
- alu_a  out  DATA_W  to ALUnit A.
- alu_b  out  DATA_W  to ALUnit B.
- alu_result  in  DATA_W  from ALUnit dataOut.
- alu_flags  in  4  from ALUnit, ordered {Z,V,C,N}.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  DATA_W  captured result.
- res_flags  out  4  captured {Z,V,C,N}.
- busy  out  1  high when the FSM is not IDLE or the queue is non-empty.
- fifo_count  out  log2(FIFO_DEPTH)+1  queue occupancy.

Behaviour:
- Reset (asynchronous, rst_n low) forces the following, and takes effect mid-operation with in-flight and queued commands discarded:
  - state to IDLE and queue empty;
  - alu_oper, alu_a, alu_b, res_data, res_flags and fifo_count to 0;
  - res_valid and busy to 0;
  - cmd_ready to 1.
- Command queue:
  - Circular FIFO; cmd_ready = (fifo_count != FIFO_DEPTH).
  - A push occurs on a clock edge when cmd_valid && cmd_ready.
  - A push and a pop in the same edge leave fifo_count unchanged.
  - When full, cmd_ready is low, so no push is possible; the slot frees one edge after the pop.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states are IDLE, WAIT and DONE:
  - IDLE: if the queue is non-empty, pop the head, register it onto alu_oper/alu_a/alu_b, load cnt=ALU_LAT, and go to WAIT. If the queue is empty, stay in IDLE.
  - WAIT: alu_* are held stable. If cnt!=0, decrement cnt. If cnt==0, capture alu_result→res_data and alu_flags→res_flags, set res_valid=1, and go to DONE.
  - DONE: res_data, res_flags and res_valid are held stable until res_ready. On an edge with res_valid && res_ready, clear res_valid and return to IDLE. Queued commands keep accumulating while in DONE (backpressure).
- alu_* keep the last issued command after completion; ALUnit is never given new operands while a result is pending.
- Latency: for a command pushed at edge T into an empty queue with the FSM in IDLE:
  - pop occurs at T+1;
  - res_valid is high after T+ALU_LAT+2 (T+3 at default).
- Back-to-back throughput is one command per ALU_LAT+3 edges when res_ready is held high.
- Commands complete strictly in FIFO order; exactly one result is produced per issued command.

Optional Feature:
- Macro: ALU_SEQ_NOP_SKIP_EN.
- Defined: in IDLE, a head command with oper==000 is popped and discarded in one edge. The FSM stays in IDLE, alu_* are not updated, and no result is produced; a following command may be popped on the next edge.
- Undefined: NOP is issued to the ALU like any other opcode and produces a result/flags beat.

Test Plan:
- Reset then idle: rst_n low for 3 cycles → all outputs 0, cmd_ready=1; rst_n high with no commands → busy=0, res_valid stays 0.
- Single ADD: push oper=001, A=0x0003, B=0x0004 at edge T, res_ready=1 → res_valid after T+3, res_data=0x0007, Z=0, held 1 cycle.
- SUB zero flag: A=0x5, B=0x5, oper=010 → res_data=0, res_flags[3] (Z)=1.
- Full/backpressure:
  - push 5 commands with res_ready=0 → cmd_ready=0 after 4 are accepted beyond the issued one (fifo_count=4);
  - the first result is held stable in DONE;
  - raising res_ready drains all 5 results in push order.
- Reset mid-operation: assert rst_n low while in WAIT with 2 commands queued → res_valid=0, fifo_count=0 immediately; after release no stale result appears.
- NOP: push NOP then ADD(1,1) → with ALU_SEQ_NOP_SKIP_EN only one beat (0x2); without it two beats, the first carrying the NOP result.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues {oper, A, B} commands, issues them one at a time
// to the clocked ALUnit, waits ALU_LAT edges, then captures the result and
// {Z,V,C,N} flags and holds them on a valid/ready result port.
// Optional build macro: ALU_SEQ_NOP_SKIP_EN. When it is defined, NOP commands
// (oper == 3'b000) are dropped from the queue without reaching the ALU.
module alu_cmd_sequencer #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,   // power of 2, at least 2
  parameter int ALU_LAT    = 1    // at least 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [2:0]                    cmd_oper,
  input  logic [DATA_W-1:0]             cmd_a,
  input  logic [DATA_W-1:0]             cmd_b,
  output logic [2:0]                    alu_oper,
  output logic [DATA_W-1:0]             alu_a,
  output logic [DATA_W-1:0]             alu_b,
  input  logic [DATA_W-1:0]             alu_result,
  input  logic [3:0]                    alu_flags,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DATA_W-1:0]             res_data,
  output logic [3:0]                    res_flags,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);
  localparam int ENT_W = 3 + 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Queue storage and bookkeeping
  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q,  count_d;

  // Sequencer state
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        alu_oper_q, alu_oper_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [3:0]        res_flags_q, res_flags_d;

  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [ENT_W-1:0]  head;
  logic [2:0]        head_oper;
  logic [DATA_W-1:0] head_a;
  logic [DATA_W-1:0] head_b;

  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = (count_q != (AW + 1)'(FIFO_DEPTH));
  assign push       = cmd_valid && cmd_ready;

  // The head entry is read straight from the array; the ALU operand
  // registers act as the read register, so the pop itself is registered.
  assign head      = mem_q[rd_ptr_q];
  assign head_oper = head[ENT_W-1 -: 3];
  assign head_a    = head[2*DATA_W-1 -: DATA_W];
  assign head_b    = head[DATA_W-1:0];

  // Queue array write; contents need no reset because occupancy gates reads
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_oper, cmd_a, cmd_b};
    end
  end

  // Next pointers and occupancy; power-of-2 depth makes wrap free
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FSM next state, issue, latency countdown and result capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    alu_oper_d  = alu_oper_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
`ifdef ALU_SEQ_NOP_SKIP_EN
          // A NOP head is consumed here and never reaches the ALU
          if (head_oper != 3'b000) begin
            alu_oper_d = head_oper;
            alu_a_d    = head_a;
            alu_b_d    = head_b;
            cnt_d      = CW'(ALU_LAT);
            state_d    = WAIT;
          end
`else
          alu_oper_d = head_oper;
          alu_a_d    = head_a;
          alu_b_d    = head_b;
          cnt_d      = CW'(ALU_LAT);
          state_d    = WAIT;
`endif
        end
      end

      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          res_data_d  = alu_result;
          res_flags_d = alu_flags;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        // Result stays put until the consumer takes it
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, queue bookkeeping and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_oper_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alu_oper_q  <= alu_oper_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
    end
  end

  assign alu_oper   = alu_oper_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_flags  = res_flags_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a one-edge behavioural ALU.
module tb_alu_cmd_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_oper;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [2:0]  alu_oper;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_flags;
  logic        busy;
  logic [2:0]  fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  alu_cmd_sequencer #(.DATA_W(32), .FIFO_DEPTH(4), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_oper(cmd_oper), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flags(res_flags),
    .busy(busy), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Stand-in ALUnit: result and {Z,V,C,N} one edge after sampling inputs
  function automatic logic [35:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic c, v;
    r = '0; c = 1'b0; v = 1'b0; w = '0;
    case (op)
      3'd1: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
                  v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd2: begin r = a - b; c = (a < b); v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd7: r = a << b[4:0];
      default: r = '0;
    endcase
    return {(r == 32'd0), v, c, r[31], r};
  endfunction

  always @(posedge clk) {alu_flags, alu_result} <= alu_model(alu_oper, alu_a, alu_b);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    cmd_valid = 1'b1; cmd_oper = op; cmd_a = a; cmd_b = b;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Advance until res_valid is seen (bounded), then check the beat
  task automatic expect_beat(input string tag, input logic [31:0] exp_d, input logic [3:0] exp_f);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 64'(res_valid), 64'd1);
    check({tag, "_data"},  64'(res_data),  64'(exp_d));
    check({tag, "_flags"}, 64'(res_flags), 64'(exp_f));
    $display("beat %s: data=0x%08h flags=%04b", tag, res_data, res_flags);
  endtask

  logic [2:0]  bp_op [5];
  logic [31:0] bp_a  [5];
  logic [31:0] bp_b  [5];
  logic [31:0] bp_d  [5];
  logic [3:0]  bp_f  [5];
  int          seen;

  initial begin
    bp_op[0] = 3'd1; bp_a[0] = 32'd10;     bp_b[0] = 32'd20;     bp_d[0] = 32'd30;         bp_f[0] = 4'b0000;
    bp_op[1] = 3'd2; bp_a[1] = 32'd7;      bp_b[1] = 32'd9;      bp_d[1] = 32'hFFFF_FFFE;  bp_f[1] = 4'b0011;
    bp_op[2] = 3'd3; bp_a[2] = 32'hF0F0;   bp_b[2] = 32'hFF00;   bp_d[2] = 32'hF000;       bp_f[2] = 4'b0000;
    bp_op[3] = 3'd4; bp_a[3] = 32'h0F;     bp_b[3] = 32'hF0;     bp_d[3] = 32'hFF;         bp_f[3] = 4'b0000;
    bp_op[4] = 3'd7; bp_a[4] = 32'd1;      bp_b[4] = 32'd4;      bp_d[4] = 32'd16;         bp_f[4] = 4'b0000;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_oper = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;

    // Reset held for 3 cycles
    repeat (3) @(negedge clk);
    check("rst_alu_oper",  64'(alu_oper),   64'd0);
    check("rst_alu_a",     64'(alu_a),      64'd0);
    check("rst_alu_b",     64'(alu_b),      64'd0);
    check("rst_res_data",  64'(res_data),   64'd0);
    check("rst_res_flags", 64'(res_flags),  64'd0);
    check("rst_res_valid", 64'(res_valid),  64'd0);
    check("rst_busy",      64'(busy),       64'd0);
    check("rst_count",     64'(fifo_count), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready),  64'd1);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_busy",  64'(busy),      64'd0);
    check("idle_valid", 64'(res_valid), 64'd0);

    // Single ADD, exact latency: push at T, valid after T+3, held one cycle
    res_ready = 1'b1;
    push_cmd(3'd1, 32'd3, 32'd4);                 // edge T
    check("add_count_T", 64'(fifo_count), 64'd1);
    tick();                                       // T+1: pop/issue
    check("add_count_T1", 64'(fifo_count), 64'd0);
    check("add_alu_oper", 64'(alu_oper), 64'd1);
    check("add_alu_a",    64'(alu_a),    64'd3);
    check("add_alu_b",    64'(alu_b),    64'd4);
    check("add_busy",     64'(busy),     64'd1);
    tick();                                       // T+2
    check("add_valid_T2", 64'(res_valid), 64'd0);
    tick();                                       // T+3
    check("add_valid_T3", 64'(res_valid), 64'd1);
    check("add_data",     64'(res_data),  64'd7);
    check("add_flags",    64'(res_flags), 64'd0);
    $display("beat add: data=0x%08h flags=%04b", res_data, res_flags);
    tick();                                       // T+4: handshake
    check("add_valid_T4", 64'(res_valid), 64'd0);
    check("add_busy_end", 64'(busy),      64'd0);
    check("add_alu_hold", 64'(alu_a),     64'd3);

    // SUB with zero result sets Z
    push_cmd(3'd2, 32'd5, 32'd5);
    expect_beat("sub", 32'd0, 4'b1000);
    tick();
    check("sub_cleared", 64'(res_valid), 64'd0);

    // Fill the queue while the consumer stalls
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_ready_push", 64'(cmd_ready), 64'd1);
      push_cmd(bp_op[i], bp_a[i], bp_b[i]);
    end
    check("bp_count_full", 64'(fifo_count), 64'd4);
    check("bp_ready_full", 64'(cmd_ready),  64'd0);
    push_cmd(3'd1, 32'd99, 32'd99);               // refused: queue full
    check("bp_count_hold", 64'(fifo_count), 64'd4);
    check("bp_valid",      64'(res_valid),  64'd1);
    check("bp_data_first", 64'(res_data),   64'd30);
    repeat (2) tick();
    check("bp_valid_held", 64'(res_valid),  64'd1);
    check("bp_data_held",  64'(res_data),   64'd30);
    check("bp_alu_a_held", 64'(alu_a),      64'd10);
    check("bp_busy",       64'(busy),       64'd1);
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_beat($sformatf("drain%0d", i), bp_d[i], bp_f[i]);
      tick();
    end
    check("drain_busy",  64'(busy),       64'd0);
    check("drain_count", 64'(fifo_count), 64'd0);

    // Asynchronous reset while in WAIT with two commands queued
    push_cmd(3'd1, 32'd1, 32'd1);
    push_cmd(3'd1, 32'd2, 32'd2);
    push_cmd(3'd1, 32'd3, 32'd3);
    check("mid_count", 64'(fifo_count), 64'd2);
    check("mid_valid_pre", 64'(res_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(res_valid),  64'd0);
    check("mid_rst_count", 64'(fifo_count), 64'd0);
    check("mid_rst_alu_a", 64'(alu_a),      64'd0);
    check("mid_rst_ready", 64'(cmd_ready),  64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (res_valid !== 1'b0) seen++;
    end
    check("mid_no_stale", 64'(seen), 64'd0);
    check("mid_busy",     64'(busy), 64'd0);

    // NOP followed by ADD(1,1)
    push_cmd(3'd0, 32'd5, 32'd6);
    push_cmd(3'd1, 32'd1, 32'd1);
`ifndef ALU_SEQ_NOP_SKIP_EN
    expect_beat("nop", 32'd0, 4'b1000);
    tick();
`endif
    expect_beat("nop_add", 32'd2, 4'b0000);
    tick();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (res_valid !== 1'b0) seen++;
      tick();
    end
    check("final_no_extra", 64'(seen), 64'd0);
    check("final_busy",     64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
